// File: rtl/lc3_operand_regfile.sv
// lc3_operand_regfile
//   LC-3 general-purpose register file (R0-R7) with the SR2MUX operand
//   select stage that feeds the ALU, plus the N/Z/P condition-code register.
//
//   Ports:
//     clk, reset          - system clock; synchronous active-high reset
//     sr1, sr2            - source register indices for OPA / OPB
//     imm5, sr2mux_sel    - immediate field and OPB source select (1 = imm5)
//     rd_en               - capture operands into the OPA/OPB latches
//     ld_reg, dr, bus_in  - single write port from the processor bus
//     ld_cc               - update N/Z/P from bus_in
//     opa, opb, op_valid  - registered ALU operands and one-cycle valid pulse
//     n, z, p             - registered condition codes
//
//   Parameters:
//     BYPASS   - 1: a same-cycle write to a register being read is forwarded
//                into the operand latch; 0: the latch sees the pre-write value
//     CC_RESET - {n,z,p} after reset
module lc3_operand_regfile #(
   parameter bit         BYPASS   = 1'b1,
   parameter logic [2:0] CC_RESET = 3'b010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  sr1,
   input  logic [2:0]  sr2,
   input  logic [4:0]  imm5,
   input  logic        sr2mux_sel,
   input  logic        rd_en,
   input  logic        ld_reg,
   input  logic [2:0]  dr,
   input  logic [15:0] bus_in,
   input  logic        ld_cc,
   output logic [15:0] opa,
   output logic [15:0] opb,
   output logic        op_valid,
   output logic        n,
   output logic        z,
   output logic        p
);

   logic [15:0] regs_q [0:7];
   logic [15:0] regs_d [0:7];
   logic [15:0] opa_q, opa_d;
   logic [15:0] opb_q, opb_d;
   logic        op_valid_q, op_valid_d;
   logic [2:0]  cc_q, cc_d;

   logic [15:0] src_a_s;
   logic [15:0] src_b_s;

   // Sign-extend the 5-bit immediate to the 16-bit datapath width.
   function automatic logic [15:0] sext_imm5(input logic [4:0] imm);
      return {{11{imm[4]}}, imm};
   endfunction

   // Derive the one-hot {n,z,p} code for a 16-bit two's-complement value.
   function automatic logic [2:0] cc_of(input logic [15:0] val);
      logic is_zero;
      is_zero = (val == 16'h0000);
      return {val[15], is_zero, ~val[15] & ~is_zero};
   endfunction

   // Register array next-state: single write port.
   always_comb begin
      regs_d = regs_q;
      if (ld_reg) begin
         regs_d[dr] = bus_in;
      end else begin
         regs_d[dr] = regs_q[dr];
      end
   end

   // Operand source selection, with optional forwarding of the in-flight write
   // so a read in the same cycle as a write sees the new value.
   always_comb begin
      if (BYPASS && ld_reg && (dr == sr1)) begin
         src_a_s = bus_in;
      end else begin
         src_a_s = regs_q[sr1];
      end
      if (sr2mux_sel) begin
         src_b_s = sext_imm5(imm5);
      end else if (BYPASS && ld_reg && (dr == sr2)) begin
         src_b_s = bus_in;
      end else begin
         src_b_s = regs_q[sr2];
      end
   end

   // Operand latch, valid pulse and condition-code next-state.
   always_comb begin
      op_valid_d = rd_en;
      if (rd_en) begin
         opa_d = src_a_s;
         opb_d = src_b_s;
      end else begin
         opa_d = opa_q;
         opb_d = opb_q;
      end
      if (ld_cc) begin
         cc_d = cc_of(bus_in);
      end else begin
         cc_d = cc_q;
      end
   end

   // State registers; reset overrides every load enable in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= 16'h0000;
         end
         opa_q      <= 16'h0000;
         opb_q      <= 16'h0000;
         op_valid_q <= 1'b0;
         cc_q       <= CC_RESET;
      end else begin
         regs_q     <= regs_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         op_valid_q <= op_valid_d;
         cc_q       <= cc_d;
      end
   end

   assign opa      = opa_q;
   assign opb      = opb_q;
   assign op_valid = op_valid_q;
   assign n        = cc_q[2];
   assign z        = cc_q[1];
   assign p        = cc_q[0];

endmodule
